// File: rtl/tile_sprite_fetch.sv
// Board-tile sprite source: fetches one procedurally defined sprite line per request
// and serialises it one pixel per accepted beat, optionally mirrored.
module tile_sprite_fetch #(
  parameter int LINE_W = 32,
  parameter int ROWS   = 16,
  parameter int TILE_W = 2,
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(LINE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TILE_W-1:0] req_tile,
  input  logic [ROW_W-1:0]  req_row,
  input  logic              req_mirror,
  output logic [LINE_W-1:0] line_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [COL_W-1:0]  pix_col,
  output logic              pix_last
);

  localparam int S = LINE_W / ROWS;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t            state, state_nx;
  logic [TILE_W-1:0] tile_q;
  logic [ROW_W-1:0]  row_q;
  logic              mir_q;
  logic [LINE_W-1:0] line_q, sreg, tbl_line, tbl_rev;
  logic [COL_W-1:0]  col;
  logic              beat, last_col;

  assign beat     = (state == SHIFT) && pix_ready;
  assign last_col = (col == COL_W'(LINE_W - 1));

  // Sprite table: column c lands on bit LINE_W-1-c so the leftmost pixel is the MSB.
  always_comb begin
    tbl_line = '0;
    if (int'(row_q) < ROWS) begin
      for (int c = 0; c < LINE_W; c++) begin
        case (int'(tile_q))
          1: tbl_line[LINE_W-1-c] = 1'b1;
          2: if ((c / S) == int'(row_q) || (c / S) == (ROWS - 1 - int'(row_q)))
               tbl_line[LINE_W-1-c] = 1'b1;
          3: if (int'(row_q) == 0 || int'(row_q) == ROWS - 1 || c == 0 || c == LINE_W - 1)
               tbl_line[LINE_W-1-c] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    tbl_rev = '0;
    for (int i = 0; i < LINE_W; i++) tbl_rev[i] = tbl_line[LINE_W-1-i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = FETCH;
      end
      FETCH:   state_nx = SHIFT;
      SHIFT:   if (beat && last_col) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_q <= '0;
      row_q  <= '0;
      mir_q  <= 1'b0;
      line_q <= '0;
      sreg   <= '0;
      col    <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        tile_q <= req_tile;
        row_q  <= req_row;
        mir_q  <= req_mirror;
      end
      if (state == FETCH) begin
        line_q <= tbl_line;
        sreg   <= mir_q ? tbl_rev : tbl_line;
        col    <= '0;
      end else if (beat) begin
        sreg <= sreg << 1;
        // wrap explicitly so non-power-of-two widths never leave the 0..LINE_W-1 range
        col  <= last_col ? '0 : col + COL_W'(1);
      end
    end
  end

  assign line_data = line_q;
  assign pix_valid = (state == SHIFT);
  assign pix_data  = pix_valid & sreg[LINE_W-1];
  assign pix_col   = col;
  assign pix_last  = pix_valid & last_col;

endmodule
